// File: rtl/neuron_accumulator.sv
// neuron_accumulator: sums bias plus sign-magnitude Q5.10 products, then saturates, applies optional ReLU and hands the result out via valid/ready.
module neuron_accumulator #(
    parameter int ACC_W = 26,
    parameter bit RELU  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [15:0] bias_i,
    input  logic [15:0] in_data_i,
    input  logic        in_valid_i,
    input  logic        in_last_i,
    output logic        in_ready_o,
    output logic [15:0] out_data_o,
    output logic        out_valid_o,
    input  logic        out_ready_i
);
    typedef enum logic [1:0] {IDLE, ACCUM, FINAL, OUTPUT} state_t;
    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [15:0]        out_q, out_d;
    logic               vld_q, vld_d;
    logic               neg, sat;
    logic [ACC_W-1:0]   mag;
    logic [15:0]        result;
    function automatic logic [ACC_W-1:0] conv(input logic [15:0] x);
        logic [ACC_W-1:0] m;
        m = ACC_W'(x[14:0]);
        return x[15] ? -m : m;
    endfunction
    // Saturation is any magnitude bit above bit 14; negative zero cannot occur since acc=0 has neg=0.
    assign neg    = acc_q[ACC_W-1];
    assign mag    = neg ? -acc_q : acc_q;
    assign sat    = |mag[ACC_W-1:15];
    assign result = neg ? (RELU ? 16'h0000 : (sat ? 16'hFFFF : {1'b1, mag[14:0]}))
                        : (sat ? 16'h7FFF : {1'b0, mag[14:0]});
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        out_d   = out_q;
        vld_d   = vld_q;
        case (state_q)
            IDLE: if (start_i) begin
                acc_d   = conv(bias_i);
                state_d = ACCUM;
            end
            ACCUM: if (in_valid_i) begin
                acc_d   = acc_q + conv(in_data_i);
                state_d = in_last_i ? FINAL : ACCUM;
            end
            FINAL: begin
                out_d   = result;
                vld_d   = 1'b1;
                state_d = OUTPUT;
            end
            OUTPUT: if (out_ready_i) begin
                vld_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
        end
    end
    assign in_ready_o  = (state_q == ACCUM);
    assign out_data_o  = out_q;
    assign out_valid_o = vld_q;
endmodule

// File: tb/tb_neuron_accumulator.sv
// tb_neuron_accumulator: drives RELU=1 and RELU=0 instances in lockstep and checks results against a scoreboard model.
module tb_neuron_accumulator;
    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_last, out_ready;
    logic [15:0] bias, in_data;
    logic        in_ready1, in_ready0, out_valid1, out_valid0;
    logic [15:0] out_data1, out_data0;
    int          tests = 0, fails = 0, acc_m = 0;
    logic [15:0] q1[$], q0[$];
    always #5 clk = ~clk;
    neuron_accumulator #(.ACC_W(26), .RELU(1'b1)) u1 (
        .clk(clk), .reset(reset), .start_i(start), .bias_i(bias), .in_data_i(in_data),
        .in_valid_i(in_valid), .in_last_i(in_last), .in_ready_o(in_ready1),
        .out_data_o(out_data1), .out_valid_o(out_valid1), .out_ready_i(out_ready));
    neuron_accumulator #(.ACC_W(26), .RELU(1'b0)) u0 (
        .clk(clk), .reset(reset), .start_i(start), .bias_i(bias), .in_data_i(in_data),
        .in_valid_i(in_valid), .in_last_i(in_last), .in_ready_o(in_ready0),
        .out_data_o(out_data0), .out_valid_o(out_valid0), .out_ready_i(out_ready));
    function automatic int conv(input logic [15:0] x);
        return x[15] ? -int'(x[14:0]) : int'(x[14:0]);
    endfunction
    function automatic logic [15:0] model(input int a, input bit relu);
        int m;
        m = (a < 0) ? -a : a;
        if (a > 32767) return 16'h7FFF;
        if (a < -32767) return relu ? 16'h0000 : 16'hFFFF;
        if (a < 0) return relu ? 16'h0000 : {1'b1, m[14:0]};
        return {1'b0, m[14:0]};
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic begin_neuron(input logic [15:0] b);
        start = 1'b1;
        bias  = b;
        acc_m = conv(b);
        tick();
        start = 1'b0;
        chk("in_ready_after_start_r1", in_ready1, 1);
        chk("in_ready_after_start_r0", in_ready0, 1);
    endtask
    task automatic put(input logic [15:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        acc_m   += conv(d);
        if (last) begin
            q1.push_back(model(acc_m, 1'b1));
            q0.push_back(model(acc_m, 1'b0));
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask
    task automatic gap();
        in_data = 16'h7FFF;
        in_last = 1'b1;
        tick();
        in_last = 1'b0;
    endtask
    task automatic collect(input string tag, input int exp_wait);
        int n = 0;
        while (!out_valid1 && n < 8) begin
            tick();
            n++;
        end
        chk({tag, "_valid_r1"}, out_valid1, 1);
        chk({tag, "_valid_r0"}, out_valid0, 1);
        if (exp_wait >= 0) chk({tag, "_latency"}, 16'(n), 16'(exp_wait));
        chk({tag, "_data_r1"}, out_data1, q1.size() > 0 ? q1.pop_front() : 16'hxxxx);
        chk({tag, "_data_r0"}, out_data0, q0.size() > 0 ? q0.pop_front() : 16'hxxxx);
    endtask
    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, out_valid1, 0);
        chk({tag, "_idle_ready"}, in_ready1, 0);
    endtask
    initial begin
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        bias = 16'h0; in_data = 16'h0;
        tick(); tick();
        reset = 1'b1;
        chk("rst_out_valid", out_valid1, 0);
        chk("rst_in_ready", in_ready1, 0);
        chk("rst_out_data", out_data1, 16'h0000);
        begin_neuron(16'h0400);
        put(16'h0A00, 1'b0);
        put(16'h8600, 1'b1);
        chk("basic_final_not_valid", out_valid1, 0);
        collect("basic", 1);
        chk("basic_const", out_data1, 16'h0800);
        release_out("basic");
        begin_neuron(16'h7C00);
        put(16'h7C00, 1'b0);
        put(16'h7C00, 1'b1);
        collect("pos_sat", 1);
        chk("pos_sat_const", out_data0, 16'h7FFF);
        release_out("pos_sat");
        begin_neuron(16'hFC00);
        put(16'hFC00, 1'b0);
        put(16'hFC00, 1'b1);
        collect("neg_sat", 1);
        chk("neg_sat_const_r0", out_data0, 16'hFFFF);
        chk("neg_sat_const_r1", out_data1, 16'h0000);
        release_out("neg_sat");
        begin_neuron(16'h0000);
        put(16'h8400, 1'b1);
        collect("relu", 1);
        chk("relu_const_r1", out_data1, 16'h0000);
        chk("relu_const_r0", out_data0, 16'h8400);
        release_out("relu");
        begin_neuron(16'h8000);
        put(16'h8000, 1'b1);
        collect("negzero", 1);
        chk("negzero_const", out_data0, 16'h0000);
        release_out("negzero");
        begin_neuron(16'h0000);
        put(16'h0400, 1'b0);
        gap();
        put(16'h0400, 1'b0);
        gap();
        put(16'h0400, 1'b1);
        collect("toggle", 1);
        chk("toggle_const", out_data1, 16'h0C00);
        for (int i = 0; i < 5; i++) begin
            start    = i[0];
            bias     = 16'h7C00;
            in_valid = 1'b1;
            in_data  = 16'h7C00;
            tick();
            chk("hold_data_r1", out_data1, 16'h0C00);
            chk("hold_data_r0", out_data0, 16'h0C00);
            chk("hold_valid", out_valid1, 1);
            chk("hold_in_ready", in_ready1, 0);
        end
        in_valid = 1'b0;
        start    = 1'b1;
        release_out("b2b");
        start = 1'b0;
        tick();
        chk("b2b_start_ignored", in_ready1, 0);
        begin_neuron(16'h0400);
        put(16'h7C00, 1'b0);
        put(16'h7C00, 1'b0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("midrst_out_valid", out_valid1, 0);
        chk("midrst_in_ready", in_ready1, 0);
        chk("midrst_out_data_r1", out_data1, 16'h0000);
        chk("midrst_out_data_r0", out_data0, 16'h0000);
        begin_neuron(16'h0400);
        put(16'h0400, 1'b1);
        collect("fresh", 1);
        chk("fresh_const", out_data1, 16'h0800);
        release_out("fresh");
        chk("sb_empty", 16'(q1.size() + q0.size()), 16'h0000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
